uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
- UART receive controller that sits directly downstream of the baud tick generator (clkuart_pwm) and consumes its output.
- Detects a start bit on the serial line, asserts bps_en to start the generator's bit counter, and samples rxd on each mid-bit clk_uart pulse.
- Assembles the frame (start, DATA_BITS data LSB-first, optional parity, one stop bit).
- Presents the received byte with a one-cycle valid strobe, plus error strobes, to the bus-side logic.

Parameters:
- DATA_BITS, 8, number of data bits per frame; legal range 5..8.
- PARITY_EN, 0, 1 = a parity bit follows the data bits.
- PARITY_ODD, 0, 1 = odd parity, 0 = even parity; ignored when PARITY_EN = 0.

Ports:
- clk  input  1  system clock; same clock as the baud generator.
- RST  input  1  asynchronous reset, active-high.
- rxd  input  1  serial line; asynchronous to clk; idles high.
- clk_uart  input  1  one-clk-wide mid-bit sample tick from the baud generator.
- bps_en  output  1  enables the baud generator; its counter holds at 0 while this is low.
- rx_data  output  DATA_BITS  last good received word.
- rx_valid  output  1  one-cycle strobe; rx_data updated this cycle.
- frame_err  output  1  one-cycle strobe; stop bit sampled low.
- parity_err  output  1  one-cycle strobe; parity mismatch, frame otherwise good.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (RST high, async):
  - state = IDLE; synchroniser flops = 1; bps_en = 0; rx_data = 0.
  - rx_valid, frame_err, parity_err = 0; shift register and bit counter = 0.
  - Reset mid-frame aborts the frame with no strobe.
- Synchroniser: rxd passes through 2 flops to give rxd_s, plus one history flop rxd_d. Start detect = rxd_d & ~rxd_s.
- State machine:
  - IDLE: on start detect, go to START and set bps_en = 1 (registered).
  - START: on clk_uart, if rxd_s = 0 go to DATA with bit counter = 0. Otherwise this is a false start: go to IDLE and set bps_en = 0 the next cycle.
  - DATA: on each clk_uart, shift rxd_s into the MSB end so the LSB arrives first, and increment the counter. After the DATA_BITS-th tick, go to PARITY if PARITY_EN, else STOP.
  - PARITY: on clk_uart, capture rxd_s as the parity bit and go to STOP.
  - STOP:
    - On clk_uart with rxd_s = 1: if parity is good or disabled, load rx_data and pulse rx_valid; if parity is bad, pulse parity_err and leave rx_data unchanged. Then go to IDLE.
    - On clk_uart with rxd_s = 0: pulse frame_err, leave rx_data unchanged, go to WAIT_HIGH.
    - bps_en drops in the cycle after the stop tick in both cases.
  - WAIT_HIGH: bps_en = 0; go to IDLE when rxd_s = 1. A start detect is not accepted until rxd_d = 1, which prevents a break condition from re-triggering.
- Parity check: even parity requires XOR(data, parity bit) = 0; odd parity requires it to be 1.
- Bit timing: the first tick arrives about BPS_PARA/2 clocks after bps_en rises, i.e. mid start bit. Later ticks follow every BPS_PARA clocks.
- Ticks that arrive while in IDLE or WAIT_HIGH are ignored.
- Strobe timing: rx_valid, frame_err and parity_err fire in the clk cycle after the stop-bit tick. At most one of them is high in any cycle.
- Back-to-back frames: a start bit immediately after a stop bit is accepted, because IDLE is re-entered about BPS_PARA/2 clocks before the stop bit ends.
- rx_data holds its value until the next good frame. There is no overrun detection; the consumer must take rx_data within one frame time.

Test Plan:
All scenarios instantiate clkuart_pwm with BPS_PARA=347; its active-low reset is driven by ~RST.
- Send 0xA5, 8N1 -> a single rx_valid pulse about 9.5×347 clocks after the start edge; rx_data = 0xA5; bps_en low afterwards; busy low.
- Hold rxd low for 100 clocks only -> no strobe; bps_en falls within 2 cycles of the first tick; state returns to IDLE.
- Send 0x3C with stop bit = 0 and hold the line low for 2 bit times -> one frame_err pulse; rx_data keeps its previous value; no restart until rxd goes high, then 0x7E is received correctly.
- Send 0x00 then 0xFF back-to-back with no idle gap -> two rx_valid pulses; rx_data = 0x00, then 0xFF.
- Assert RST during data bit 4 of 0x55 -> all outputs return to reset values immediately; after release, 0x81 is received correctly.
- PARITY_EN=1, PARITY_ODD=0: send 0x01 with parity bit 1 -> rx_valid; send 0x01 with parity bit 0 -> parity_err pulse and rx_data remains 0x01.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start-bit detect, mid-bit sampling on the baud
// generator's tick, frame assembly, and one-cycle result/error strobes.
module uart_rx_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic                 rxd,
  input  logic                 clk_uart,
  output logic                 bps_en,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_PARITY    = 3'd3;
  localparam logic [2:0] S_STOP      = 3'd4;
  localparam logic [2:0] S_WAIT_HIGH = 3'd5;

  localparam logic       PEN     = (PARITY_EN != 0);
  localparam logic       ODD     = (PARITY_ODD != 0);
  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

  logic                 rxd_m_q, rxd_s_q, rxd_d_q;
  logic [2:0]           state_q, state_d;
  logic                 bps_en_q, bps_en_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 par_q, par_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 start_det;
  logic                 parity_ok;

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      rxd_m_q <= 1'b1;
      rxd_s_q <= 1'b1;
      rxd_d_q <= 1'b1;
    end else begin
      rxd_m_q <= rxd;
      rxd_s_q <= rxd_m_q;
      rxd_d_q <= rxd_s_q;
    end
  end

  assign start_det = rxd_d_q & ~rxd_s_q;
  assign parity_ok = !PEN || ((^shift_q ^ par_q) == ODD);

  always_comb begin
    state_d      = state_q;
    bps_en_d     = bps_en_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    par_d        = par_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_det) begin
          state_d  = S_START;
          bps_en_d = 1'b1;
        end
      end
      S_START: begin
        if (clk_uart) begin
          if (!rxd_s_q) begin
            state_d = S_DATA;
            cnt_d   = '0;
          end else begin
            state_d  = S_IDLE;
            bps_en_d = 1'b0;
          end
        end
      end
      S_DATA: begin
        if (clk_uart) begin
          shift_d = {rxd_s_q, shift_q[DATA_BITS-1:1]};
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == LAST_BIT) begin
            state_d = PEN ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (clk_uart) begin
          par_d   = rxd_s_q;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (clk_uart) begin
          bps_en_d = 1'b0;
          if (rxd_s_q) begin
            state_d = S_IDLE;
            if (parity_ok) begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
            end else begin
              parity_err_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        // Stay here through a break so a held-low line cannot re-trigger.
        bps_en_d = 1'b0;
        if (rxd_s_q) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d  = S_IDLE;
        bps_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q      <= S_IDLE;
      bps_en_q     <= 1'b0;
      shift_q      <= '0;
      cnt_q        <= '0;
      par_q        <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bps_en_q     <= bps_en_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      par_q        <= par_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign bps_en     = bps_en_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: an 8N1 and an 8E1 receiver, each driven by a
// behavioural baud generator, checked through a strobe scoreboard.
module tb_uart_rx_ctrl;

  localparam int BPS = 40;

  typedef struct {
    int         kind;  // 0 = rx_valid, 1 = frame_err, 2 = parity_err
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic RST = 1'b1;
  logic rxd0 = 1'b1, rxd1 = 1'b1;
  logic bps_en0, bps_en1, tick0, tick1;
  logic [7:0] rx_data0, rx_data1;
  logic v0, fe0, pe0, busy0;
  logic v1, fe1, pe1, busy1;
  int unsigned bcnt0, bcnt1;

  int total = 0;
  int bad   = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic [7:0] good0 = 8'h00, good1 = 8'h00;

  always #5 clk = ~clk;

  // Baud generator model: counter held at 0 while disabled, tick at half a bit.
  always @(posedge clk or posedge RST) begin
    if (RST) bcnt0 <= 0;
    else if (!bps_en0) bcnt0 <= 0;
    else bcnt0 <= (bcnt0 == BPS - 1) ? 0 : bcnt0 + 1;
  end
  always @(posedge clk or posedge RST) begin
    if (RST) bcnt1 <= 0;
    else if (!bps_en1) bcnt1 <= 0;
    else bcnt1 <= (bcnt1 == BPS - 1) ? 0 : bcnt1 + 1;
  end
  assign tick0 = bps_en0 && (bcnt0 == BPS / 2);
  assign tick1 = bps_en1 && (bcnt1 == BPS / 2);

  uart_rx_ctrl #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
    .clk(clk), .RST(RST), .rxd(rxd0), .clk_uart(tick0), .bps_en(bps_en0),
    .rx_data(rx_data0), .rx_valid(v0), .frame_err(fe0), .parity_err(pe0),
    .busy(busy0)
  );

  uart_rx_ctrl #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
    .clk(clk), .RST(RST), .rxd(rxd1), .clk_uart(tick1), .bps_en(bps_en1),
    .rx_data(rx_data1), .rx_valid(v1), .frame_err(fe1), .parity_err(pe1),
    .busy(busy1)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_strobe(input string tag, input logic v, input logic fe,
                              input logic pe, input logic ptick,
                              input logic [7:0] rd, input exp_t e);
    int kind;
    kind = v ? 0 : (fe ? 1 : 2);
    check({tag, "_onehot"}, $countones({v, fe, pe}), 1);
    check({tag, "_after_tick"}, int'(ptick), 1);
    check({tag, "_kind"}, kind, e.kind);
    check({tag, "_rx_data"}, int'(rd), int'(e.data));
  endtask

  task automatic monitor();
    logic pt0, pt1;
    exp_t e;
    pt0 = 1'b0;
    pt1 = 1'b0;
    forever begin
      @(negedge clk);
      if (!RST) begin
        if (v0 || fe0 || pe0) begin
          if (q0.size() == 0) begin
            total++; bad++;
            $display("FAIL dut0_unexpected_strobe actual=%b%b%b expected=none", v0, fe0, pe0);
          end else begin
            e = q0.pop_front();
            check_strobe("dut0", v0, fe0, pe0, pt0, rx_data0, e);
          end
        end
        if (v1 || fe1 || pe1) begin
          if (q1.size() == 0) begin
            total++; bad++;
            $display("FAIL dut1_unexpected_strobe actual=%b%b%b expected=none", v1, fe1, pe1);
          end else begin
            e = q1.pop_front();
            check_strobe("dut1", v1, fe1, pe1, pt1, rx_data1, e);
          end
        end
      end
      pt0 = tick0;
      pt1 = tick1;
    end
  endtask

  task automatic set_line(input int which, input logic b);
    if (which == 0) rxd0 = b;
    else rxd1 = b;
  endtask

  task automatic drive_bit(input int which, input logic b);
    set_line(which, b);
    repeat (BPS) @(negedge clk);
  endtask

  // Reference: stop low beats everything, then parity, else the word is good.
  task automatic send(input int which, input logic [7:0] d, input bit pflip,
                      input bit stop, input int hold_bits, input int gap_bits);
    exp_t e;
    logic p;
    logic [7:0] g;
    p = (^d) ^ pflip;
    g = (which == 0) ? good0 : good1;
    if (!stop) e = '{kind: 1, data: g};
    else if (which == 1 && pflip) e = '{kind: 2, data: g};
    else begin
      e = '{kind: 0, data: d};
      if (which == 0) good0 = d; else good1 = d;
    end
    if (which == 0) q0.push_back(e); else q1.push_back(e);
    drive_bit(which, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(which, d[i]);
    if (which == 1) drive_bit(which, p);
    drive_bit(which, stop);
    if (!stop) begin
      repeat (hold_bits * BPS) @(negedge clk);
      set_line(which, 1'b1);
    end
    repeat (gap_bits * BPS) @(negedge clk);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 30 * BPS && (q0.size() != 0 || q1.size() != 0 || busy0 || busy1); i++)
      @(negedge clk);
    repeat (3) @(negedge clk);
    check({name, "_pending"}, q0.size() + q1.size(), 0);
    check({name, "_bps_en0"}, int'(bps_en0), 0);
    check({name, "_busy0"}, int'(busy0), 0);
    check({name, "_bps_en1"}, int'(bps_en1), 0);
    check({name, "_busy1"}, int'(busy1), 0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_rx_data0"}, int'(rx_data0), 0);
    check({name, "_strobes0"}, int'({v0, fe0, pe0}), 0);
    check({name, "_bps_en0"}, int'(bps_en0), 0);
    check({name, "_busy0"}, int'(busy0), 0);
    check({name, "_rx_data1"}, int'(rx_data1), 0);
    check({name, "_strobes1"}, int'({v1, fe1, pe1}), 0);
    check({name, "_bps_en1"}, int'(bps_en1), 0);
    check({name, "_busy1"}, int'(busy1), 0);
  endtask

  initial begin
    bit saw_en;
    logic [7:0] d;
    bit stop, pflip;

    fork
      monitor();
    join_none

    repeat (5) @(negedge clk);
    check_reset_outputs("reset");
    RST = 1'b0;
    repeat (5) @(negedge clk);

    // Plain 8N1 word.
    send(0, 8'hA5, 1'b0, 1'b1, 0, 1);
    drain("a5");
    check("a5_rx_data0", int'(rx_data0), 8'hA5);

    // Glitch shorter than half a bit: generator enabled, then released.
    saw_en = 1'b0;
    rxd0 = 1'b0;
    repeat (8) @(negedge clk);
    rxd0 = 1'b1;
    for (int i = 0; i < 3 * BPS; i++) begin
      @(negedge clk);
      if (bps_en0) saw_en = 1'b1;
    end
    check("false_start_en_seen", int'(saw_en), 1);
    drain("false_start");

    // Stop bit low followed by a break, then a clean frame.
    send(0, 8'h3C, 1'b0, 1'b0, 2, 1);
    send(0, 8'h7E, 1'b0, 1'b1, 0, 1);
    drain("break");
    check("break_rx_data0", int'(rx_data0), 8'h7E);

    // Back-to-back frames with no idle gap.
    send(0, 8'h00, 1'b0, 1'b1, 0, 0);
    send(0, 8'hFF, 1'b0, 1'b1, 0, 1);
    drain("b2b");

    // Reset during data bit 4 of 0x55.
    d = 8'h55;
    drive_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(0, d[i]);
    set_line(0, d[4]);
    repeat (BPS / 2) @(negedge clk);
    check("pre_reset_busy0", int'(busy0), 1);
    RST = 1'b1;
    #1;
    check_reset_outputs("midframe_reset");
    rxd0 = 1'b1;
    good0 = 8'h00;
    good1 = 8'h00;
    repeat (4) @(negedge clk);
    RST = 1'b0;
    repeat (4) @(negedge clk);
    send(0, 8'h81, 1'b0, 1'b1, 0, 1);
    drain("after_reset");
    check("after_reset_rx_data0", int'(rx_data0), 8'h81);

    // Even parity: correct parity bit, then a wrong one.
    send(1, 8'h01, 1'b0, 1'b1, 0, 1);
    send(1, 8'h01, 1'b1, 1'b1, 0, 1);
    drain("parity");
    check("parity_rx_data1", int'(rx_data1), 8'h01);

    // Random frames on both receivers.
    for (int n = 0; n < 14; n++) begin
      for (int w = 0; w < 2; w++) begin
        d     = 8'($urandom);
        stop  = ($urandom_range(0, 5) != 0);
        pflip = ($urandom_range(0, 3) == 0);
        send(w, d, pflip, stop, stop ? 0 : int'($urandom_range(0, 2)),
             stop ? int'($urandom_range(0, 2)) : 1);
      end
    end
    drain("random");
    check("random_rx_data0", int'(rx_data0), int'(good0));
    check("random_rx_data1", int'(rx_data1), int'(good1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
